// File: rtl/dcache_wbuf.sv
// Store write buffer between a write-through L1 data cache and the memory bus.
// Word stores are queued and drained to memory in order. Line refills pass
// through only once the queue is drained, which preserves read-after-write
// ordering without any address comparison.
module dcache_wbuf #(
  parameter int depth_width  = 2,
  parameter int offset_width = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  // cache side
  input  logic [31:0]                       addr_dcache_mem,
  input  logic [31:0]                       dout_dcache_mem,
  input  logic                              dcache_mem_req,
  input  logic                              dcache_mem_wr,
  input  logic [1:0]                        dcache_mem_size,
  input  logic [3:0]                        dcache_mem_wstrb,
  output logic                              mem_dcache_addrOK,
  output logic                              mem_dcache_dataOK,
  output logic [32*(1<<offset_width)-1:0]   din_mem_dcache,
  // memory side
  output logic [31:0]                       addr_wbuf_mem,
  output logic [31:0]                       dout_wbuf_mem,
  output logic                              wbuf_mem_req,
  output logic                              wbuf_mem_wr,
  output logic [1:0]                        wbuf_mem_size,
  output logic [3:0]                        wbuf_mem_wstrb,
  input  logic                              mem_wbuf_addrOK,
  input  logic                              mem_wbuf_dataOK,
  input  logic [32*(1<<offset_width)-1:0]   din_mem_wbuf,
  // status
  output logic                              wbuf_empty
);

  localparam int ENTRIES = 1 << depth_width;
  localparam logic [depth_width:0]   CNT_FULL = (depth_width+1)'(ENTRIES);
  localparam logic [depth_width:0]   CNT_ONE  = (depth_width+1)'(1);
  localparam logic [depth_width-1:0] PTR_ONE  = depth_width'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_REQ  = 3'd1,
    W_WAIT = 3'd2,
    R_REQ  = 3'd3,
    R_WAIT = 3'd4
  } state_e;

  state_e state_q, state_d;

  // queue storage (data only, never reset)
  logic [31:0] fifo_addr_q  [ENTRIES];
  logic [31:0] fifo_data_q  [ENTRIES];
  logic [1:0]  fifo_size_q  [ENTRIES];
  logic [3:0]  fifo_wstrb_q [ENTRIES];

  logic [depth_width-1:0] wptr_q, wptr_d;
  logic [depth_width-1:0] rptr_q, rptr_d;
  logic [depth_width:0]   count_q, count_d;
  logic [31:0]            raddr_q, raddr_d;
  logic                   wr_ack_q, wr_ack_d;

  logic full;
  logic empty;
  logic rd_busy;
  logic push;
  logic pop;
  logic rd_done;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  // a pending refill blocks new stores; the cache never overlaps them anyway
  assign rd_busy = (state_q == R_REQ) || (state_q == R_WAIT);
  // full is taken from the registered count, so a pop never frees a slot
  // for a push in the same cycle
  assign push    = dcache_mem_req && dcache_mem_wr && !full && !rd_busy;
  assign pop     = (state_q == W_WAIT) && mem_wbuf_dataOK;
  assign rd_done = (state_q == R_WAIT) && mem_wbuf_dataOK;

  // next pointers, occupancy and write-completion pulse
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    wr_ack_d = push;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // drain FSM: next state and memory-side request fields
  always_comb begin
    state_d        = state_q;
    raddr_d        = raddr_q;
    wbuf_mem_req   = 1'b0;
    wbuf_mem_wr    = 1'b0;
    addr_wbuf_mem  = '0;
    dout_wbuf_mem  = '0;
    wbuf_mem_size  = '0;
    wbuf_mem_wstrb = '0;
    case (state_q)
      IDLE: begin
        // queued stores always go before a refill
        if (!empty) begin
          state_d = W_REQ;
        end else if (dcache_mem_req && !dcache_mem_wr) begin
          state_d = R_REQ;
          raddr_d = addr_dcache_mem;
        end
      end
      W_REQ: begin
        wbuf_mem_req   = 1'b1;
        wbuf_mem_wr    = 1'b1;
        addr_wbuf_mem  = fifo_addr_q[rptr_q];
        dout_wbuf_mem  = fifo_data_q[rptr_q];
        wbuf_mem_size  = fifo_size_q[rptr_q];
        wbuf_mem_wstrb = fifo_wstrb_q[rptr_q];
        if (mem_wbuf_addrOK) begin
          state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (mem_wbuf_dataOK) begin
          state_d = (count_d != '0) ? W_REQ : IDLE;
        end
      end
      R_REQ: begin
        wbuf_mem_req  = 1'b1;
        addr_wbuf_mem = raddr_q;
        wbuf_mem_size = 2'd2;
        if (mem_wbuf_addrOK) begin
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (mem_wbuf_dataOK) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cache-side handshake: store accepts and refill accept/return are combinational
  always_comb begin
    mem_dcache_addrOK = push || ((state_q == R_REQ) && mem_wbuf_addrOK);
    mem_dcache_dataOK = wr_ack_q || rd_done;
    din_mem_dcache    = rd_done ? din_mem_wbuf : '0;
    wbuf_empty        = empty && (state_q == IDLE);
  end

  // control registers; reset abandons any in-flight memory transaction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  // queue entry write on store accept
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q]  <= addr_dcache_mem;
      fifo_data_q[wptr_q]  <= dout_dcache_mem;
      fifo_size_q[wptr_q]  <= dcache_mem_size;
      fifo_wstrb_q[wptr_q] <= dcache_mem_wstrb;
    end
  end

  // refill address register
  always_ff @(posedge clk) begin
    raddr_q <= raddr_d;
  end

endmodule

// File: tb/tb_dcache_wbuf.sv
// Scoreboard bench for dcache_wbuf: stimulus pushes expected memory requests
// and cache completions into queues; monitors pop and compare as the DUT
// presents them. A small memory responder provides programmable latency.
module tb_dcache_wbuf;

  localparam int LW = 128;
  localparam logic [LW-1:0] LINE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  wstrb;
  } me_t;

  typedef struct packed {
    logic          rd;
    logic [LW-1:0] line;
  } ce_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   addr_dcache_mem;
  logic [31:0]   dout_dcache_mem;
  logic          dcache_mem_req;
  logic          dcache_mem_wr;
  logic [1:0]    dcache_mem_size;
  logic [3:0]    dcache_mem_wstrb;
  logic          mem_dcache_addrOK;
  logic          mem_dcache_dataOK;
  logic [LW-1:0] din_mem_dcache;
  logic [31:0]   addr_wbuf_mem;
  logic [31:0]   dout_wbuf_mem;
  logic          wbuf_mem_req;
  logic          wbuf_mem_wr;
  logic [1:0]    wbuf_mem_size;
  logic [3:0]    wbuf_mem_wstrb;
  logic          mem_wbuf_addrOK;
  logic          mem_wbuf_dataOK;
  logic [LW-1:0] din_mem_wbuf;
  logic          wbuf_empty;

  dcache_wbuf #(.depth_width(2), .offset_width(2)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .addr_dcache_mem   (addr_dcache_mem),
    .dout_dcache_mem   (dout_dcache_mem),
    .dcache_mem_req    (dcache_mem_req),
    .dcache_mem_wr     (dcache_mem_wr),
    .dcache_mem_size   (dcache_mem_size),
    .dcache_mem_wstrb  (dcache_mem_wstrb),
    .mem_dcache_addrOK (mem_dcache_addrOK),
    .mem_dcache_dataOK (mem_dcache_dataOK),
    .din_mem_dcache    (din_mem_dcache),
    .addr_wbuf_mem     (addr_wbuf_mem),
    .dout_wbuf_mem     (dout_wbuf_mem),
    .wbuf_mem_req      (wbuf_mem_req),
    .wbuf_mem_wr       (wbuf_mem_wr),
    .wbuf_mem_size     (wbuf_mem_size),
    .wbuf_mem_wstrb    (wbuf_mem_wstrb),
    .mem_wbuf_addrOK   (mem_wbuf_addrOK),
    .mem_wbuf_dataOK   (mem_wbuf_dataOK),
    .din_mem_wbuf      (din_mem_wbuf),
    .wbuf_empty        (wbuf_empty)
  );

  always #5 clk = ~clk;

  int  nvec = 0;
  int  nerr = 0;
  int  cyc  = 0;
  int  last_mdok_cyc = -10;
  int  addr_lat = 0;
  int  data_lat = 0;
  bit  hold = 1'b0;
  me_t mem_exp[$];
  ce_t cache_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory responder
  initial begin : responder
    bit busy;
    int acnt;
    int dcnt;
    busy = 1'b0; acnt = 0; dcnt = 0;
    mem_wbuf_addrOK = 1'b0;
    mem_wbuf_dataOK = 1'b0;
    din_mem_wbuf    = LINE;
    forever begin
      @(posedge clk); #1;
      mem_wbuf_addrOK = 1'b0;
      mem_wbuf_dataOK = 1'b0;
      if (!rstn) begin
        busy = 1'b0; acnt = 0;
      end else if (busy) begin
        if (dcnt >= data_lat) begin
          mem_wbuf_dataOK = 1'b1;
          busy = 1'b0;
        end else begin
          dcnt++;
        end
      end else if (wbuf_mem_req && !hold) begin
        if (acnt >= addr_lat) begin
          mem_wbuf_addrOK = 1'b1;
          busy = 1'b1; dcnt = 0; acnt = 0;
        end else begin
          acnt++;
        end
      end
    end
  end

  // memory-side monitor: request order, fields, stability, read ordering
  initial begin : mem_mon
    bit  outstanding;
    bit  prev_stall;
    me_t prev_f;
    me_t cur;
    me_t e;
    outstanding = 1'b0; prev_stall = 1'b0; prev_f = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        outstanding = 1'b0; prev_stall = 1'b0;
      end else begin
        cur = '{wr: wbuf_mem_wr, addr: addr_wbuf_mem, data: dout_wbuf_mem,
                size: wbuf_mem_size, wstrb: wbuf_mem_wstrb};
        if (prev_stall && wbuf_mem_req) chk("mem_hold_stable", LW'(cur), LW'(prev_f));
        if (mem_wbuf_dataOK) begin
          outstanding = 1'b0;
          last_mdok_cyc = cyc;
        end
        if (wbuf_mem_req && mem_wbuf_addrOK) begin
          if (mem_exp.size() == 0) begin
            chk("mem_unexpected_req", LW'(addr_wbuf_mem), LW'(0));
          end else begin
            e = mem_exp.pop_front();
            chk("mem_wr",    LW'(wbuf_mem_wr),    LW'(e.wr));
            chk("mem_addr",  LW'(addr_wbuf_mem),  LW'(e.addr));
            chk("mem_size",  LW'(wbuf_mem_size),  LW'(e.size));
            chk("mem_wstrb", LW'(wbuf_mem_wstrb), LW'(e.wstrb));
            if (e.wr) chk("mem_data", LW'(dout_wbuf_mem), LW'(e.data));
            else      chk("read_after_writes", LW'(outstanding), LW'(0));
          end
          outstanding = 1'b1;
        end
        prev_stall = wbuf_mem_req && !mem_wbuf_addrOK;
        prev_f     = cur;
      end
    end
  end

  // cache-side monitor: completion pulses and refill data
  initial begin : cache_mon
    bit  wacc_prev;
    ce_t e;
    wacc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        wacc_prev = 1'b0;
      end else begin
        if (wacc_prev) chk("wr_dataok_next_cycle", LW'(mem_dcache_dataOK), LW'(1));
        if (mem_dcache_dataOK) begin
          if (cache_exp.size() == 0) begin
            chk("cache_unexpected_dataok", LW'(mem_dcache_dataOK), LW'(0));
          end else begin
            e = cache_exp.pop_front();
            if (e.rd) begin
              chk("read_line", din_mem_dcache, e.line);
              chk("read_dataok_same_cycle", LW'(mem_wbuf_dataOK), LW'(1));
            end else begin
              chk("wr_dataok_kind", LW'(wacc_prev), LW'(1));
            end
          end
        end
        wacc_prev = mem_dcache_addrOK && dcache_mem_req && dcache_mem_wr;
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input logic [3:0] sb, input bit imm, output int acc);
    int  tries;
    me_t e;
    ce_t c;
    tries = 0;
    acc   = -1;
    addr_dcache_mem  = a;
    dout_dcache_mem  = d;
    dcache_mem_size  = sz;
    dcache_mem_wstrb = sb;
    dcache_mem_wr    = 1'b1;
    dcache_mem_req   = 1'b1;
    forever begin
      @(negedge clk);
      if (mem_dcache_addrOK || tries > 200) break;
      tries++;
      @(posedge clk); #1;
    end
    if (!mem_dcache_addrOK) begin
      chk("store_accept_timeout", LW'(tries), LW'(0));
    end else begin
      e = '{wr: 1'b1, addr: a, data: d, size: sz, wstrb: sb};
      c = '{rd: 1'b0, line: '0};
      mem_exp.push_back(e);
      cache_exp.push_back(c);
      acc = cyc;
      if (imm) chk("store_same_cycle_accept", LW'(tries), LW'(0));
    end
    @(posedge clk); #1;
    dcache_mem_req = 1'b0;
    dcache_mem_wr  = 1'b0;
  endtask

  task automatic line_read(input logic [31:0] a);
    int  n;
    me_t e;
    ce_t c;
    e = '{wr: 1'b0, addr: a, data: 32'h0, size: 2'd2, wstrb: 4'h0};
    c = '{rd: 1'b1, line: LINE};
    mem_exp.push_back(e);
    cache_exp.push_back(c);
    addr_dcache_mem  = a;
    dcache_mem_size  = 2'd2;
    dcache_mem_wstrb = 4'h0;
    dcache_mem_wr    = 1'b0;
    dcache_mem_req   = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_dcache_addrOK || n > 300) break;
      n++;
    end
    chk("read_accept_timeout", LW'(mem_dcache_addrOK), LW'(1));
    @(posedge clk); #1;
    dcache_mem_req = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_dcache_dataOK || n > 300) break;
      n++;
    end
    chk("read_dataok_timeout", LW'(mem_dcache_dataOK), LW'(1));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(wbuf_empty && mem_exp.size() == 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, LW'(n < 400), LW'(1));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin : main
    int acc;
    int acc5;
    rstn             = 1'b0;
    addr_dcache_mem  = '0;
    dout_dcache_mem  = '0;
    dcache_mem_req   = 1'b0;
    dcache_mem_wr    = 1'b0;
    dcache_mem_size  = '0;
    dcache_mem_wstrb = '0;
    #3;
    // reset state
    chk("rst_addrOK",    LW'(mem_dcache_addrOK), LW'(0));
    chk("rst_dataOK",    LW'(mem_dcache_dataOK), LW'(0));
    chk("rst_din",       din_mem_dcache,         LW'(0));
    chk("rst_mem_req",   LW'(wbuf_mem_req),      LW'(0));
    chk("rst_mem_wr",    LW'(wbuf_mem_wr),       LW'(0));
    chk("rst_mem_addr",  LW'(addr_wbuf_mem),     LW'(0));
    chk("rst_mem_data",  LW'(dout_wbuf_mem),     LW'(0));
    chk("rst_mem_size",  LW'(wbuf_mem_size),     LW'(0));
    chk("rst_mem_wstrb", LW'(wbuf_mem_wstrb),    LW'(0));
    chk("rst_empty",     LW'(wbuf_empty),        LW'(1));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // single store, memory addrOK after 2 cycles, dataOK 3 later
    addr_lat = 2; data_lat = 3;
    store(32'h1000_0004, 32'hDEAD_BEEF, 2'd2, 4'b1111, 1'b1, acc);
    wait_idle("single_drain");
    chk("single_empty_after_dataok", LW'(cyc), LW'(last_mdok_cyc + 1));

    // fill to full with memory stalled, fifth store waits for a pop
    @(posedge clk); #1;
    hold = 1'b1; addr_lat = 0; data_lat = 1;
    store(32'h1000_0100, 32'hA000_0001, 2'd2, 4'hF, 1'b1, acc);
    store(32'h1000_0104, 32'hA000_0002, 2'd2, 4'hF, 1'b1, acc);
    store(32'h1000_0108, 32'hA000_0003, 2'd2, 4'hF, 1'b1, acc);
    store(32'h1000_010C, 32'hA000_0004, 2'd2, 4'hF, 1'b1, acc);
    chk("full_empty_flag", LW'(wbuf_empty), LW'(0));
    fork
      store(32'h1000_0110, 32'hA000_0005, 2'd2, 4'hF, 1'b0, acc5);
      begin
        repeat (4) @(negedge clk);
        chk("full_addrOK_low", LW'(mem_dcache_addrOK), LW'(0));
        @(posedge clk); #1;
        hold = 1'b0;
      end
    join
    chk("full_accept_after_pop", LW'(acc5), LW'(last_mdok_cyc + 1));
    wait_idle("full_drain");

    // refill behind two queued stores
    @(posedge clk); #1;
    addr_lat = 1; data_lat = 2;
    store(32'h1000_0008, 32'h1111_1111, 2'd2, 4'hF, 1'b1, acc);
    store(32'h1000_000C, 32'h2222_2222, 2'd2, 4'hF, 1'b1, acc);
    line_read(32'h1000_0000);
    wait_idle("read_drain");

    // byte store forwarded unchanged
    @(posedge clk); #1;
    addr_lat = 0; data_lat = 0;
    store(32'h2000_0002, 32'h00AB_0000, 2'd0, 4'b0100, 1'b1, acc);
    wait_idle("byte_drain");

    // ten stores across pointer wrap with instant memory
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      store(32'h3000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 2'd2, 4'hF, 1'b0, acc);
    end
    wait_idle("wrap_drain");

    // reset while a store waits for memory data with three queued
    @(posedge clk); #1;
    addr_lat = 0; data_lat = 30;
    store(32'h4000_0000, 32'h5555_0001, 2'd2, 4'hF, 1'b1, acc);
    store(32'h4000_0004, 32'h5555_0002, 2'd2, 4'hF, 1'b1, acc);
    store(32'h4000_0008, 32'h5555_0003, 2'd2, 4'hF, 1'b1, acc);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("midrst_req",    LW'(wbuf_mem_req),      LW'(0));
    chk("midrst_empty",  LW'(wbuf_empty),        LW'(1));
    chk("midrst_dataOK", LW'(mem_dcache_dataOK), LW'(0));
    mem_exp.delete();
    cache_exp.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    addr_lat = 1; data_lat = 1;
    store(32'h5000_0010, 32'h0BAD_F00D, 2'd1, 4'b0011, 1'b1, acc);
    wait_idle("post_rst_drain");

    repeat (3) @(negedge clk);
    chk("mem_exp_drained",   LW'(mem_exp.size()),   LW'(0));
    chk("cache_exp_drained", LW'(cache_exp.size()), LW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
